// File: rtl/decode_operand_fetch.sv
// Decode / operand-fetch pipeline stage: instruction register, 16x16 register file,
// load-use stall FSM and back-to-back ALU forwarding flags for the execute stage.
module decode_operand_fetch #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned REG_COUNT  = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           instr,
  input  logic                  instrValid,
  output logic                  instrAccept,
  output logic [3:0]            opcode,
  output logic [3:0]            destReg,
  output logic [DATA_WIDTH-1:0] srcVal1,
  output logic [DATA_WIDTH-1:0] srcVal2,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  used1,
  output logic                  used2,
  input  logic [3:0]            destRegStore,
  input  logic [DATA_WIDTH-1:0] destVal,
  input  logic                  storeNow,
  output logic                  storeDone,
  output logic                  halted
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_HALT  = 4'd1;
  localparam logic [3:0] OP_NEG   = 4'd9;
  localparam logic [3:0] OP_LOAD  = 4'd14;
  localparam logic [3:0] OP_STORE = 4'd15;

  typedef enum logic [1:0] {
    RUN,
    LOADWAIT,
    HALTED
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            pending_q, pending_d;
  logic [15:0]           ir_q;
  logic                  irValid_q;

  logic [DATA_WIDTH-1:0] rf_q [REG_COUNT];

  logic [3:0]            opcode_q, opcode_d;
  logic [3:0]            destReg_q, destReg_d;
  logic [DATA_WIDTH-1:0] srcVal1_q, srcVal1_d;
  logic [DATA_WIDTH-1:0] srcVal2_q, srcVal2_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic                  used1_q, used1_d;
  logic                  used2_q, used2_d;
  logic                  storeDone_q;
  logic                  halted_q;

  logic [3:0]            irOp, irDst, irS1, irS2;
  logic                  irBlocks;
  logic                  prevAlu;
  logic [DATA_WIDTH-1:0] rdS1, rdS2, rdDst;

  assign irOp  = ir_q[15:12];
  assign irDst = ir_q[11:8];
  assign irS1  = ir_q[7:4];
  assign irS2  = ir_q[3:0];

  // A LOAD or HALT sitting in the instruction register will move the FSM out of
  // RUN on the next edge, so nothing may be accepted behind it.
  assign irBlocks    = irValid_q && (irOp == OP_LOAD || irOp == OP_HALT);
  assign instrAccept = rst && (state_q == RUN) && !irBlocks && instrValid;

  assign prevAlu = (opcode_q >= 4'd2) && (opcode_q <= 4'd10);

  // Same-cycle writeback wins over the stale array contents.
  assign rdS1  = (storeNow && destRegStore == irS1)  ? destVal : rf_q[irS1];
  assign rdS2  = (storeNow && destRegStore == irS2)  ? destVal : rf_q[irS2];
  assign rdDst = (storeNow && destRegStore == irDst) ? destVal : rf_q[irDst];

  always_comb begin
    opcode_d  = OP_NOP;
    destReg_d = '0;
    srcVal1_d = '0;
    srcVal2_d = '0;
    memAddr_d = '0;
    used1_d   = 1'b0;
    used2_d   = 1'b0;
    if (state_q == RUN && irValid_q) begin
      case (irOp)
        OP_HALT: opcode_d = OP_HALT;
        4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10: begin
          opcode_d  = irOp;
          destReg_d = irDst;
          srcVal1_d = rdS1;
          srcVal2_d = rdS2;
          used1_d   = prevAlu && (irS1 == destReg_q);
          used2_d   = prevAlu && (irS2 == destReg_q);
        end
        OP_NEG: begin
          opcode_d  = OP_NEG;
          destReg_d = irDst;
          srcVal1_d = rdS1;
          used1_d   = prevAlu && (irS1 == destReg_q);
        end
        OP_LOAD: begin
          opcode_d  = OP_LOAD;
          destReg_d = irDst;
          memAddr_d = ADDR_WIDTH'(ir_q[7:0]);
        end
        OP_STORE: begin
          opcode_d  = OP_STORE;
          destReg_d = irDst;
          srcVal1_d = rdDst;
          memAddr_d = ADDR_WIDTH'(ir_q[7:0]);
          used1_d   = prevAlu && (irDst == destReg_q);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      RUN: begin
        if (irValid_q && irOp == OP_LOAD) begin
          state_d   = LOADWAIT;
          pending_d = irDst;
        end else if (irValid_q && irOp == OP_HALT) begin
          state_d = HALTED;
        end
      end
      LOADWAIT: if (storeNow && destRegStore == pending_q) state_d = RUN;
      HALTED:   state_d = HALTED;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      pending_q   <= '0;
      ir_q        <= '0;
      irValid_q   <= 1'b0;
      opcode_q    <= '0;
      destReg_q   <= '0;
      srcVal1_q   <= '0;
      srcVal2_q   <= '0;
      memAddr_q   <= '0;
      used1_q     <= 1'b0;
      used2_q     <= 1'b0;
      storeDone_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      if (instrAccept) ir_q <= instr;
      irValid_q   <= instrAccept;
      opcode_q    <= opcode_d;
      destReg_q   <= destReg_d;
      srcVal1_q   <= srcVal1_d;
      srcVal2_q   <= srcVal2_d;
      memAddr_q   <= memAddr_d;
      used1_q     <= used1_d;
      used2_q     <= used2_d;
      storeDone_q <= storeNow;
      halted_q    <= (state_d == HALTED);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (storeNow) begin
      rf_q[destRegStore] <= destVal;
    end
  end

  assign opcode    = opcode_q;
  assign destReg   = destReg_q;
  assign srcVal1   = srcVal1_q;
  assign srcVal2   = srcVal2_q;
  assign memAddr   = memAddr_q;
  assign used1     = used1_q;
  assign used2     = used2_q;
  assign storeDone = storeDone_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_decode_operand_fetch.sv
// Directed bench for decode_operand_fetch: reset, writeback, issue, forwarding,
// load stall, bypass, store, illegal opcodes, halt and mid-state reset.
module tb_decode_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instrValid;
  logic        instrAccept;
  logic [3:0]  opcode;
  logic [3:0]  destReg;
  logic [15:0] srcVal1;
  logic [15:0] srcVal2;
  logic [7:0]  memAddr;
  logic        used1;
  logic        used2;
  logic [3:0]  destRegStore;
  logic [15:0] destVal;
  logic        storeNow;
  logic        storeDone;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_operand_fetch #(.DATA_WIDTH(16), .REG_COUNT(16), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instrValid(instrValid),
    .instrAccept(instrAccept), .opcode(opcode), .destReg(destReg),
    .srcVal1(srcVal1), .srcVal2(srcVal2), .memAddr(memAddr),
    .used1(used1), .used2(used2), .destRegStore(destRegStore),
    .destVal(destVal), .storeNow(storeNow), .storeDone(storeDone), .halted(halted)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; instr = 16'h2C34; instrValid = 1'b1;
    storeNow = 1'b0; destRegStore = '0; destVal = '0;
    tick; tick;
    checks++; if (instrAccept !== 1'b0) begin failures++; $display("FAIL rst_accept got=%0h exp=0", instrAccept); end
    checks++; if (opcode !== 4'd0) begin failures++; $display("FAIL rst_opcode got=%0h exp=0", opcode); end
    checks++; if (destReg !== 4'd0 || memAddr !== 8'd0) begin failures++; $display("FAIL rst_dest_addr got=%0h/%0h exp=0/0", destReg, memAddr); end
    checks++; if (srcVal1 !== 16'd0 || srcVal2 !== 16'd0) begin failures++; $display("FAIL rst_src got=%0h/%0h exp=0/0", srcVal1, srcVal2); end
    checks++; if ({used1, used2, storeDone, halted} !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {used1, used2, storeDone, halted}); end
    instrValid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_writeback_add;
    storeNow = 1'b1; destRegStore = 4'd3; destVal = 16'd24;
    tick;
    checks++; if (storeDone !== 1'b1) begin failures++; $display("FAIL wb_done1 got=%0h exp=1", storeDone); end
    destRegStore = 4'd4; destVal = 16'd30;
    tick;
    checks++; if (storeDone !== 1'b1) begin failures++; $display("FAIL wb_done2 got=%0h exp=1", storeDone); end
    storeNow = 1'b0; instr = 16'h2C34; instrValid = 1'b1;
    #1;
    checks++; if (instrAccept !== 1'b1) begin failures++; $display("FAIL add_accept got=%0h exp=1", instrAccept); end
    tick;
    instrValid = 1'b0;
    checks++; if (storeDone !== 1'b0) begin failures++; $display("FAIL wb_done_pulse got=%0h exp=0", storeDone); end
    checks++; if (opcode !== 4'd0) begin failures++; $display("FAIL add_latency got=%0h exp=0", opcode); end
    tick;
    checks++; if (opcode !== 4'd2 || destReg !== 4'd12) begin failures++; $display("FAIL add_op_dest got=%0h/%0h exp=2/c", opcode, destReg); end
    checks++; if (srcVal1 !== 16'd24 || srcVal2 !== 16'd30) begin failures++; $display("FAIL add_src got=%0d/%0d exp=24/30", srcVal1, srcVal2); end
    checks++; if (used1 !== 1'b0 || used2 !== 1'b0) begin failures++; $display("FAIL add_used got=%b%b exp=00", used1, used2); end
    tick;
    checks++; if (opcode !== 4'd0) begin failures++; $display("FAIL add_hold got=%0h exp=0", opcode); end
  endtask

  task automatic test_forwarding;
    instr = 16'h2512; instrValid = 1'b1;
    tick;
    instr = 16'h3655;
    tick;
    instrValid = 1'b0;
    checks++; if (opcode !== 4'd2 || used1 !== 1'b0 || used2 !== 1'b0) begin failures++; $display("FAIL fwd_first got=%0h %b%b exp=2 00", opcode, used1, used2); end
    tick;
    checks++; if (opcode !== 4'd3 || destReg !== 4'd6) begin failures++; $display("FAIL fwd_sub got=%0h/%0h exp=3/6", opcode, destReg); end
    checks++; if (used1 !== 1'b1 || used2 !== 1'b1) begin failures++; $display("FAIL fwd_both got=%b%b exp=11", used1, used2); end
    // XOR r7,r1,r5 right behind ADD r5: only operand 2 matches
    instr = 16'h2512; instrValid = 1'b1;
    tick;
    instr = 16'hA715;
    tick;
    instrValid = 1'b0;
    tick;
    checks++; if (opcode !== 4'd10 || used1 !== 1'b0 || used2 !== 1'b1) begin failures++; $display("FAIL fwd_src2 got=%0h %b%b exp=a 01", opcode, used1, used2); end
    instr = 16'h2512; instrValid = 1'b1;
    tick;
    instrValid = 1'b0;
    tick;
    instr = 16'h3655; instrValid = 1'b1;
    tick;
    instrValid = 1'b0;
    tick;
    checks++; if (opcode !== 4'd3 || used1 !== 1'b0 || used2 !== 1'b0) begin failures++; $display("FAIL fwd_nop_gap got=%0h %b%b exp=3 00", opcode, used1, used2); end
  endtask

  task automatic test_load_stall;
    instr = 16'hE71A; instrValid = 1'b1;
    tick;
    instr = 16'h2871;
    #1;
    checks++; if (instrAccept !== 1'b0) begin failures++; $display("FAIL ld_accept_ir got=%0h exp=0", instrAccept); end
    tick;
    checks++; if (opcode !== 4'd14 || destReg !== 4'd7 || memAddr !== 8'd26) begin failures++; $display("FAIL ld_issue got=%0h/%0h/%0d exp=e/7/26", opcode, destReg, memAddr); end
    checks++; if (instrAccept !== 1'b0) begin failures++; $display("FAIL ld_wait_accept got=%0h exp=0", instrAccept); end
    storeNow = 1'b1; destRegStore = 4'd6; destVal = 16'h0077;
    tick;
    storeNow = 1'b0;
    checks++; if (opcode !== 4'd0 || used1 !== 1'b0 || instrAccept !== 1'b0) begin failures++; $display("FAIL ld_bubble got=%0h %b %b exp=0 0 0", opcode, used1, instrAccept); end
    storeNow = 1'b1; destRegStore = 4'd7; destVal = 16'h1234;
    #1;
    checks++; if (instrAccept !== 1'b0) begin failures++; $display("FAIL ld_wb_cycle_accept got=%0h exp=0", instrAccept); end
    tick;
    storeNow = 1'b0;
    #1;
    checks++; if (instrAccept !== 1'b1 || opcode !== 4'd0) begin failures++; $display("FAIL ld_resume got=%0h/%0h exp=1/0", instrAccept, opcode); end
    tick;
    instrValid = 1'b0;
    tick;
    checks++; if (opcode !== 4'd2 || destReg !== 4'd8) begin failures++; $display("FAIL ld_use_op got=%0h/%0h exp=2/8", opcode, destReg); end
    checks++; if (srcVal1 !== 16'h1234 || srcVal2 !== 16'h0000 || used1 !== 1'b0) begin failures++; $display("FAIL ld_use_src got=%0h/%0h %b exp=1234/0 0", srcVal1, srcVal2, used1); end
  endtask

  task automatic test_bypass;
    instr = 16'h9A93; instrValid = 1'b1;
    tick;
    instrValid = 1'b0;
    storeNow = 1'b1; destRegStore = 4'd9; destVal = 16'hBEEF;
    tick;
    storeNow = 1'b0;
    checks++; if (opcode !== 4'd9 || destReg !== 4'd10) begin failures++; $display("FAIL byp_op got=%0h/%0h exp=9/a", opcode, destReg); end
    checks++; if (srcVal1 !== 16'hBEEF || srcVal2 !== 16'h0000 || used2 !== 1'b0) begin failures++; $display("FAIL byp_src got=%0h/%0h %b exp=beef/0 0", srcVal1, srcVal2, used2); end
  endtask

  task automatic test_store;
    storeNow = 1'b1; destRegStore = 4'd2; destVal = 16'd45;
    tick;
    storeNow = 1'b0;
    instr = 16'hF2B4; instrValid = 1'b1;
    tick;
    instrValid = 1'b0;
    tick;
    checks++; if (opcode !== 4'd15 || memAddr !== 8'd180) begin failures++; $display("FAIL st_op got=%0h/%0d exp=f/180", opcode, memAddr); end
    checks++; if (srcVal1 !== 16'd45 || used1 !== 1'b0) begin failures++; $display("FAIL st_data got=%0d %b exp=45 0", srcVal1, used1); end
    instr = 16'h2234; instrValid = 1'b1;
    tick;
    instr = 16'hF2B4;
    tick;
    instrValid = 1'b0;
    tick;
    checks++; if (opcode !== 4'd15 || used1 !== 1'b1 || srcVal1 !== 16'd45) begin failures++; $display("FAIL st_fwd got=%0h %b %0d exp=f 1 45", opcode, used1, srcVal1); end
  endtask

  task automatic test_illegal;
    instr = 16'hC123; instrValid = 1'b1;
    tick;
    instr = 16'h2512;
    #1;
    checks++; if (instrAccept !== 1'b1) begin failures++; $display("FAIL ill_consumed got=%0h exp=1", instrAccept); end
    tick;
    instrValid = 1'b0;
    checks++; if (opcode !== 4'd0 || destReg !== 4'd0) begin failures++; $display("FAIL ill_nop got=%0h/%0h exp=0/0", opcode, destReg); end
    tick;
    checks++; if (opcode !== 4'd2 || used1 !== 1'b0) begin failures++; $display("FAIL ill_next got=%0h %b exp=2 0", opcode, used1); end
  endtask

  task automatic test_halt;
    instr = 16'h1000; instrValid = 1'b1;
    tick;
    instr = 16'h2512;
    #1;
    checks++; if (instrAccept !== 1'b0) begin failures++; $display("FAIL halt_block got=%0h exp=0", instrAccept); end
    tick;
    checks++; if (opcode !== 4'd1 || halted !== 1'b1 || instrAccept !== 1'b0) begin failures++; $display("FAIL halt_issue got=%0h %b %b exp=1 1 0", opcode, halted, instrAccept); end
    storeNow = 1'b1; destRegStore = 4'd11; destVal = 16'h5555;
    tick;
    storeNow = 1'b0;
    checks++; if (opcode !== 4'd0 || halted !== 1'b1 || storeDone !== 1'b1) begin failures++; $display("FAIL halt_idle got=%0h %b %b exp=0 1 1", opcode, halted, storeDone); end
    rst = 1'b0;
    tick;
    checks++; if (halted !== 1'b0 || instrAccept !== 1'b0 || opcode !== 4'd0) begin failures++; $display("FAIL halt_rst got=%b %b %0h exp=0 0 0", halted, instrAccept, opcode); end
    rst = 1'b1;
    instr = 16'h2C34;
    #1;
    checks++; if (instrAccept !== 1'b1) begin failures++; $display("FAIL halt_resume got=%0h exp=1", instrAccept); end
    tick;
    instrValid = 1'b0;
    tick;
    checks++; if (opcode !== 4'd2 || srcVal1 !== 16'd0 || srcVal2 !== 16'd0) begin failures++; $display("FAIL rst_regs_clear got=%0h %0h/%0h exp=2 0/0", opcode, srcVal1, srcVal2); end
  endtask

  task automatic test_reset_loadwait;
    instr = 16'hE71A; instrValid = 1'b1;
    tick;
    instrValid = 1'b0;
    tick;
    checks++; if (opcode !== 4'd14 || memAddr !== 8'd26) begin failures++; $display("FAIL lwr_issue got=%0h/%0d exp=e/26", opcode, memAddr); end
    instr = 16'h2C34; instrValid = 1'b1;
    rst = 1'b0;
    tick;
    checks++; if (opcode !== 4'd0 || memAddr !== 8'd0 || destReg !== 4'd0 || instrAccept !== 1'b0) begin failures++; $display("FAIL lwr_rst got=%0h/%0h/%0h %b exp=0/0/0 0", opcode, memAddr, destReg, instrAccept); end
    rst = 1'b1;
    #1;
    checks++; if (instrAccept !== 1'b1) begin failures++; $display("FAIL lwr_resume got=%0h exp=1", instrAccept); end
    tick;
    instrValid = 1'b0;
    tick;
    checks++; if (opcode !== 4'd2 || destReg !== 4'd12) begin failures++; $display("FAIL lwr_issue_after got=%0h/%0h exp=2/c", opcode, destReg); end
  endtask

  initial begin
    test_reset;
    test_writeback_add;
    test_forwarding;
    test_load_stall;
    test_bypass;
    test_store;
    test_illegal;
    test_halt;
    test_reset_loadwait;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_operand_fetch.md
Name: decode_operand_fetch

Overview:
- Middle pipeline stage. Accepts 16-bit instructions from the fetch stage, decodes them and reads a 16x16 register file.
- Issues registered operands to executeAndStoreBack.
- Owns the register file: executeAndStoreBack writes results back through the destRegStore/destVal/storeNow port.
- Inserts bubbles on load-use hazards and flags back-to-back ALU dependencies with used1/used2 so execute forwards its LastComputedValue.

Parameters:
DATA_WIDTH, 16, register/operand width
REG_COUNT, 16, architectural registers (4-bit index)
ADDR_WIDTH, 8, data memory address width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-low reset (rst==0 at posedge resets)
instr  input  16  instruction from fetch
instrValid  input  1  instr holds a valid instruction
instrAccept  output  1  decoder consumes instr this cycle (instrValid && instrAccept)
opcode  output  4  issued opcode (0 = NOP bubble)
destReg  output  4  issued destination register
srcVal1  output  16  operand 1 (register value, or store data)
srcVal2  output  16  operand 2
memAddr  output  8  load/store address
used1  output  1  execute replaces srcVal1 with its LastComputedValue
used2  output  1  execute replaces srcVal2 with its LastComputedValue
destRegStore  input  4  writeback register index
destVal  input  16  writeback value
storeNow  input  1  write destVal into destRegStore this cycle
storeDone  output  1  writeback acknowledge pulse
halted  output  1  HALT has been issued; decoder idle

Behaviour:
- Instruction format:
  - ALU ops: [15:12] opcode, [11:8] dest, [7:4] src1, [3:0] src2.
  - LOAD (14): [11:8] dest, [7:0] memAddr.
  - STORE (15): [11:8] data reg, [7:0] memAddr.
- Opcode classes:
  - 0 NOP.
  - 1 HALT.
  - 2 ADD, 3 SUB, 4 MUL, 5 SL, 6 SR, 7 AND, 8 OR, 10 XOR: use src1 and src2.
  - 9 NEG: uses src1 only; srcVal2=0, used2=0.
  - 11-13: illegal; issued as NOP (opcode 0) and consumed.
- Reset (rst==0):
  - All registers cleared to 0.
  - opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2, storeDone, halted = 0.
  - instrAccept = 0.
  - State = RUN; pending-load tracker cleared.
  - Reset mid-load abandons the wait.
- Issue latency: outputs are registered; an instruction accepted at edge N appears on the execute outputs after edge N+1 and holds for one cycle.
- Writeback:
  - storeNow=1 writes destVal to reg[destRegStore] at the edge.
  - storeDone=1 on the following cycle for exactly one cycle.
  - Writes to any index, including 0, are legal.
- Read bypass: if storeNow targets a register being read in the same cycle, the operand takes destVal, not the stale array value.
- Forwarding flags:
  - used1=1 iff src1 equals destReg of the instruction issued in the immediately preceding cycle and that instruction was an ALU op (2-10). used2 follows the same rule for src2.
  - A STORE's data register uses the used1 rule.
  - Bubbles and loads never set used flags.
- State machine:
  - RUN:
    - instrAccept = instrValid.
    - LOAD issued -> record pendingReg = dest; go to LOADWAIT.
    - HALT issued -> go to HALTED.
  - LOADWAIT:
    - instrAccept = 0; NOP bubbles issued.
    - Exit to RUN when storeNow && destRegStore == pendingReg. The bypass supplies the loaded value to the next issue.
  - HALTED:
    - instrAccept = 0; halted = 1; NOPs issued.
    - Writebacks still accepted.
    - Only reset leaves HALTED.
- instrValid=0 in RUN: issue NOP; used flags = 0; forwarding history becomes NOP.
- Width rules: memAddr = instr[7:0] zero-extended to nothing (exact 8 bits); no arithmetic is performed in this block.

Test Plan:
- Reset, then write reg3=24 and reg4=30 via storeNow; issue ADD r12,r3,r4 (0x2C34) -> next cycle opcode=2, destReg=12, srcVal1=24, srcVal2=30, used1=used2=0; storeDone pulses once per write.
- ADD r5,r1,r2 then back-to-back SUB r6,r5,r5 -> second issue used1=1, used2=1; NOP between them -> used flags 0.
- LOAD r7,@26 (0xE71A) then ADD r8,r7,r1 valid -> opcode=14, memAddr=26, destReg=7; instrAccept=0 with NOP bubbles until storeNow r7=0x1234; ADD then issues with srcVal1=0x1234, used1=0.
- Same-cycle read/write: storeNow r9=0xBEEF while NEG r10,r9 is decoded -> srcVal1=0xBEEF, srcVal2=0.
- STORE r2,@180 with r2=45 -> opcode=15, memAddr=180, srcVal1=45. Illegal opcode 12 -> opcode 0 issued, instruction consumed.
- HALT (0x1000) -> halted=1, instrAccept=0, NOPs thereafter; storeNow still updates a register; rst=0 mid-LOADWAIT or HALTED -> all outputs 0, RUN resumes.
